mac_vlg_rx_framer: RTL and testbench
====================================

Name: mac_vlg_rx_framer

Overview:
- Receive-side framing stage directly downstream of the PHY byte stream: data, valid and error bytes arriving on the `phy` interface's input side.
- Detects preamble/SFD, strips preamble, SFD and 4-byte FCS, and checks CRC32 over the frame.
- Delivers payload bytes (destination MAC through last data byte) with start/end markers and a per-frame status to the MAC header parser.
- Keeps saturating good/bad frame counters.

Parameters:
- PREAMBLE_MIN, 5, minimum count of 0x55 bytes required before SFD; range 1..7.
- MIN_LEN, 60, minimum payload length in bytes, FCS excluded; shorter frames are runts.
- MAX_LEN, 1514, maximum payload length in bytes, FCS excluded; longer frames are giants.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on next clk edge).
- in_dat  in  8  PHY receive byte.
- in_val  in  1  PHY byte valid; high for the whole frame.
- in_err  in  1  PHY symbol error, qualified by in_val.
- out_dat  out  8  payload byte.
- out_val  out  1  out_dat valid.
- out_sof  out  1  first payload byte; only with out_val.
- out_eof  out  1  last payload byte; only with out_val.
- out_fcs_ok  out  1  CRC residue correct; valid only with out_eof.
- out_err  out  1  frame bad (FCS, runt, giant, or in_err seen); valid only with out_eof.
- cnt_good  out  CNT_W  frames ending with out_err=0; saturates at all-ones.
- cnt_bad  out  CNT_W  frames ending with out_err=1, plus dropped frames; saturates.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE, delay line empty, CRC register 0xFFFFFFFF.
- States:
  - IDLE: in_val && in_dat==0x55 -> PRE, pcnt=1. in_val && any other byte -> DROP.
  - PRE:
    - in_dat==0x55: pcnt++, saturating at 7.
    - in_dat==0xD5 with pcnt>=PREAMBLE_MIN -> PAYLOAD; CRC init; len=0; flags cleared.
    - Any other byte, or SFD with pcnt<PREAMBLE_MIN -> DROP; cnt_bad++.
    - in_val low -> IDLE silently.
  - PAYLOAD:
    - Each valid byte: update CRC32 (reflected poly 0xEDB88320, LSB first); push into 4-byte delay line; len++, saturating at MAX_LEN+5.
    - in_err sets a sticky error flag.
  - FLUSH (first cycle with in_val low after PAYLOAD): emit the final payload byte if any; return to IDLE.
  - DROP: wait for in_val low -> IDLE; no output.
- Delay/latency:
  - Payload byte i (0-based after SFD) is registered into a hold stage when byte i+4 arrives.
  - It is presented on out_dat/out_val in the cycle after byte i+5 arrives.
  - The final payload byte is presented in the FLUSH cycle with out_eof=1.
  - out_sof accompanies byte 0.
  - The 4 bytes remaining in the delay line at FLUSH are the FCS and are discarded.
- Status at eof:
  - out_fcs_ok = (CRC register after last FCS byte == 0xDEBB20E3), non-inverted residue.
  - Runt: payload len < MIN_LEN.
  - Giant: payload len > MAX_LEN.
  - out_err = !out_fcs_ok | runt | giant | sticky error flag.
- Degenerate frame: 1..4 bytes after SFD produces no output; cnt_bad++. A 5-byte frame emits a single byte with out_sof=out_eof=1 and out_err=1 (runt).
- Back-to-back frames: one cycle of in_val low is sufficient. The FLUSH cycle doubles as that idle cycle, and a frame starting on the next cycle is accepted.
- Counters update in the out_eof cycle, or in the cycle DROP is entered.
- Reset mid-frame: outputs clear immediately; no eof is produced for the aborted frame. If in_val is still high after reset releases, the remaining bytes of that frame are non-0x55 and hit IDLE -> DROP.

Decomposition:
- mac_vlg_pkg holds:
  - PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5.
  - CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF, CRC_RESIDUE=0xDEBB20E3.
  - State enum rx_fsm_t {IDLE, PRE, PAYLOAD, FLUSH, DROP}.
- Sub-module eth_vlg_crc32: byte-wide CRC32 with clk, rst, init, en, dat[7:0] inputs and crc[31:0] output; updates one byte per enabled cycle. Reused by the TX path.

Test Plan:
- 7×0x55, 0xD5, then a 60-byte payload and correct FCS -> 60 out_val beats; first has out_sof; last has out_eof, out_fcs_ok=1, out_err=0; cnt_good=1.
- Same frame with payload byte 10 XOR 0x01 -> out_eof with out_fcs_ok=0, out_err=1; cnt_bad=1; all payload bytes still delivered.
- Preamble of 3×0x55 then 0xD5, with PREAMBLE_MIN=5 -> no output; cnt_bad=1. A following legal frame after 1 idle cycle is received intact.
- 40-byte payload with valid FCS -> 40 beats; eof beat has out_fcs_ok=1, out_err=1 (runt).
- in_err pulsed on payload byte 20 -> eof beat has out_err=1, out_fcs_ok=1.
- rst=0 for one cycle at payload byte 30 -> outputs 0 next cycle; no eof for that frame. Next full frame gives cnt_good=1, cnt_bad=1 (remainder dropped).

Source files
------------

// File: rtl/mac_vlg_pkg.sv
// Shared constants, state encoding and the byte-wide CRC32 step for the
// receive framer and its CRC engine.
package mac_vlg_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  // The last four bytes after SFD are the FCS, so payload lags input by this much.
  localparam int          DLY_DEPTH     = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    PAYLOAD,
    FLUSH,
    DROP
  } rx_fsm_t;

  // Reflected CRC32: fold the whole byte in, then shift out eight bits LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  dat);
    logic [31:0] c;
    c = crc ^ {24'h0, dat};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_vlg_crc32.sv
// Byte-wide CRC32 register; init has priority over en. Shared with the TX path.
module eth_vlg_crc32
  import mac_vlg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  dat,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc32_byte(crc_q, dat);
    end
  end

  // NOTE: state is assigned with <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mac_vlg_rx_framer.sv
// Receive framer: finds preamble/SFD, strips preamble, SFD and FCS, checks CRC32,
// and streams payload with sof/eof and per-frame status plus good/bad counters.
module mac_vlg_rx_framer
  import mac_vlg_pkg::*;
#(
  parameter int PREAMBLE_MIN = 5,
  parameter int MIN_LEN      = 60,
  parameter int MAX_LEN      = 1514,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_dat,
  input  logic             in_val,
  input  logic             in_err,
  output logic [7:0]       out_dat,
  output logic             out_val,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_fcs_ok,
  output logic             out_err,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad
);

  // len counts every byte after SFD, FCS included, and saturates one past giant.
  localparam int               LEN_W     = $clog2(MAX_LEN + 6);
  localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(MAX_LEN + 5);
  localparam logic [LEN_W-1:0] RUNT_LIM  = LEN_W'(MIN_LEN + DLY_DEPTH);
  localparam logic [LEN_W-1:0] GIANT_LIM = LEN_W'(MAX_LEN + DLY_DEPTH);
  localparam logic [2:0]       PRE_MIN   = 3'(PREAMBLE_MIN);
  localparam logic [2:0]       DLY_FULL  = 3'(DLY_DEPTH);

  rx_fsm_t          state_q,      state_d;
  logic [2:0]       pcnt_q,       pcnt_d;
  logic [LEN_W-1:0] len_q,        len_d;
  logic             err_q,        err_d;
  logic [3:0][7:0]  dly_q,        dly_d;
  logic [2:0]       dly_cnt_q,    dly_cnt_d;
  logic [7:0]       hold_dat_q,   hold_dat_d;
  logic             hold_val_q,   hold_val_d;
  logic             hold_sof_q,   hold_sof_d;
  logic [7:0]       out_dat_q,    out_dat_d;
  logic             out_val_q,    out_val_d;
  logic             out_sof_q,    out_sof_d;
  logic             out_eof_q,    out_eof_d;
  logic             out_fcs_ok_q, out_fcs_ok_d;
  logic             out_err_q,    out_err_d;
  logic [CNT_W-1:0] cnt_good_q,   cnt_good_d;
  logic [CNT_W-1:0] cnt_bad_q,    cnt_bad_d;

  logic        crc_init;
  logic        crc_en;
  logic [31:0] crc;
  logic        fcs_ok;
  logic        runt;
  logic        giant;
  logic        good_inc;
  logic        bad_inc;

  eth_vlg_crc32 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .dat  (in_dat),
    .crc  (crc)
  );

  assign fcs_ok = (crc == CRC_RESIDUE);
  assign runt   = (len_q < RUNT_LIM);
  assign giant  = (len_q > GIANT_LIM);

  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves one unassigned (no latches).
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    len_d        = len_q;
    err_d        = err_q;
    dly_d        = dly_q;
    dly_cnt_d    = dly_cnt_q;
    hold_dat_d   = hold_dat_q;
    hold_val_d   = hold_val_q;
    hold_sof_d   = hold_sof_q;
    out_dat_d    = out_dat_q;
    out_val_d    = 1'b0;
    out_sof_d    = 1'b0;
    out_eof_d    = 1'b0;
    out_fcs_ok_d = 1'b0;
    out_err_d    = 1'b0;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    good_inc     = 1'b0;
    bad_inc      = 1'b0;

    case (state_q)
      // FLUSH already emitted its byte on entry, so it can take a new frame like IDLE.
      IDLE, FLUSH: begin
        state_d = IDLE;
        if (in_val) begin
          if (in_dat == PREAMBLE_BYTE) begin
            state_d = PRE;
            pcnt_d  = 3'd1;
          end else begin
            state_d = DROP;
            bad_inc = 1'b1;
          end
        end
      end

      PRE: begin
        if (!in_val) begin
          state_d = IDLE;
        end else if (in_dat == PREAMBLE_BYTE) begin
          if (pcnt_q != 3'd7) pcnt_d = pcnt_q + 3'd1;
        end else if (in_dat == SFD_BYTE && pcnt_q >= PRE_MIN) begin
          state_d    = PAYLOAD;
          crc_init   = 1'b1;
          len_d      = '0;
          err_d      = 1'b0;
          dly_cnt_d  = '0;
          hold_val_d = 1'b0;
          hold_sof_d = 1'b0;
        end else begin
          state_d = DROP;
          bad_inc = 1'b1;
        end
      end

      PAYLOAD: begin
        if (in_val) begin
          crc_en = 1'b1;
          dly_d  = {dly_q[2:0], in_dat};
          if (in_err) err_d = 1'b1;
          if (len_q != LEN_SAT) len_d = len_q + LEN_W'(1);
          if (dly_cnt_q == DLY_FULL) begin
            // A byte leaving the delay line proves the held byte is not the last one.
            hold_dat_d = dly_q[3];
            hold_val_d = 1'b1;
            hold_sof_d = !hold_val_q;
            if (hold_val_q) begin
              out_val_d = 1'b1;
              out_dat_d = hold_dat_q;
              out_sof_d = hold_sof_q;
            end
          end else begin
            dly_cnt_d = dly_cnt_q + 3'd1;
          end
        end else begin
          state_d    = FLUSH;
          dly_cnt_d  = '0;
          hold_val_d = 1'b0;
          if (hold_val_q) begin
            out_val_d    = 1'b1;
            out_dat_d    = hold_dat_q;
            out_sof_d    = hold_sof_q;
            out_eof_d    = 1'b1;
            out_fcs_ok_d = fcs_ok;
            out_err_d    = !fcs_ok || runt || giant || err_q;
            good_inc     = !out_err_d;
            bad_inc      = out_err_d;
          end else begin
            bad_inc = 1'b1;
          end
        end
      end

      DROP: begin
        if (!in_val) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    cnt_good_d = cnt_good_q;
    cnt_bad_d  = cnt_bad_q;
    if (good_inc && cnt_good_q != '1) cnt_good_d = cnt_good_q + CNT_W'(1);
    if (bad_inc && cnt_bad_q != '1)   cnt_bad_d  = cnt_bad_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      // NOTE: the delay line is only four bytes, so it is reset with everything else.
      dly_q        <= '0;
      dly_cnt_q    <= '0;
      hold_dat_q   <= '0;
      hold_val_q   <= 1'b0;
      hold_sof_q   <= 1'b0;
      out_dat_q    <= '0;
      out_val_q    <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_fcs_ok_q <= 1'b0;
      out_err_q    <= 1'b0;
      cnt_good_q   <= '0;
      cnt_bad_q    <= '0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      len_q        <= len_d;
      err_q        <= err_d;
      dly_q        <= dly_d;
      dly_cnt_q    <= dly_cnt_d;
      hold_dat_q   <= hold_dat_d;
      hold_val_q   <= hold_val_d;
      hold_sof_q   <= hold_sof_d;
      out_dat_q    <= out_dat_d;
      out_val_q    <= out_val_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      out_fcs_ok_q <= out_fcs_ok_d;
      out_err_q    <= out_err_d;
      cnt_good_q   <= cnt_good_d;
      cnt_bad_q    <= cnt_bad_d;
    end
  end

  assign out_dat    = out_dat_q;
  assign out_val    = out_val_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign out_fcs_ok = out_fcs_ok_q;
  assign out_err    = out_err_q;
  assign cnt_good   = cnt_good_q;
  assign cnt_bad    = cnt_bad_q;

endmodule

// File: tb/tb_mac_vlg_rx_framer.sv
// Directed bench for mac_vlg_rx_framer: frames with computed FCS, checked beat by
// beat against the sent payload and against hand-tracked counter values.
module tb_mac_vlg_rx_framer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       in_dat = 8'h00;
  logic             in_val = 1'b0;
  logic             in_err = 1'b0;
  logic [7:0]       out_dat;
  logic             out_val;
  logic             out_sof;
  logic             out_eof;
  logic             out_fcs_ok;
  logic             out_err;
  logic [CNT_W-1:0] cnt_good;
  logic [CNT_W-1:0] cnt_bad;

  always #5 clk = ~clk;

  mac_vlg_rx_framer #(
    .PREAMBLE_MIN (5),
    .MIN_LEN      (60),
    .MAX_LEN      (1514),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_dat     (in_dat),
    .in_val     (in_val),
    .in_err     (in_err),
    .out_dat    (out_dat),
    .out_val    (out_val),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_fcs_ok (out_fcs_ok),
    .out_err    (out_err),
    .cnt_good   (cnt_good),
    .cnt_bad    (cnt_bad)
  );

  typedef struct {
    logic [7:0] dat;
    logic       sof;
    logic       eof;
    logic       ok;
    logic       err;
  } beat_t;

  beat_t      beats[$];
  logic [7:0] pay[$];
  logic [7:0] exp_pay[$];
  logic [7:0] tx[$];
  int         n_checks = 0;
  int         n_bad    = 0;

  always @(negedge clk) begin
    beat_t b;
    if (out_val) begin
      b.dat = out_dat;
      b.sof = out_sof;
      b.eof = out_eof;
      b.ok  = out_fcs_ok;
      b.err = out_err;
      beats.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bit-serial reference CRC over the (uncorrupted) payload.
  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (pay[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pay[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic build(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'(i * 7 + 3));
  endtask

  // Negative indices disable the flip / error / reset injection.
  task automatic send(input int npre, input int flip_idx, input int err_idx,
                      input int rst_idx, input bit with_fcs);
    logic [31:0] fcs;
    int          hdr;
    fcs = ~ref_crc();
    hdr = npre + 1;
    tx.delete();
    exp_pay.delete();
    for (int i = 0; i < npre; i++) tx.push_back(8'h55);
    tx.push_back(8'hD5);
    foreach (pay[i]) begin
      exp_pay.push_back((i == flip_idx) ? (pay[i] ^ 8'h01) : pay[i]);
      tx.push_back(exp_pay[i]);
    end
    if (with_fcs) begin
      for (int i = 0; i < 4; i++) tx.push_back(fcs[8*i +: 8]);
    end
    beats.delete();
    foreach (tx[k]) begin
      if (rst_idx >= 0 && k == hdr + rst_idx + 1) begin
        check("rst_out_val", 32'(out_val), 32'd0);
        check("rst_cnt_good", 32'(cnt_good), 32'd0);
        check("rst_cnt_bad", 32'(cnt_bad), 32'd0);
      end
      in_val = 1'b1;
      in_dat = tx[k];
      in_err = (err_idx >= 0 && k == hdr + err_idx);
      rst    = !(rst_idx >= 0 && k == hdr + rst_idx);
      tick();
    end
    in_val = 1'b0;
    in_err = 1'b0;
    in_dat = 8'h00;
    rst    = 1'b1;
    tick();
    #5;
  endtask

  task automatic check_frame(input string tag, input int exp_n,
                             input logic exp_ok, input logic exp_err);
    int nd;
    int nsof;
    int neof;
    nd   = 0;
    nsof = 0;
    neof = 0;
    check({tag, "_beats"}, 32'(beats.size()), 32'(exp_n));
    foreach (beats[i]) begin
      if (i < exp_pay.size() && beats[i].dat !== exp_pay[i]) nd++;
      if (beats[i].sof) nsof++;
      if (beats[i].eof) neof++;
    end
    if (exp_n > 0 && beats.size() > 0) begin
      check({tag, "_data_errs"}, 32'(nd), 32'd0);
      check({tag, "_sof_cnt"}, 32'(nsof), 32'd1);
      check({tag, "_sof_first"}, 32'(beats[0].sof), 32'd1);
      check({tag, "_eof_cnt"}, 32'(neof), 32'd1);
      check({tag, "_eof_last"}, 32'(beats[beats.size()-1].eof), 32'd1);
      check({tag, "_fcs_ok"}, 32'(beats[beats.size()-1].ok), 32'(exp_ok));
      check({tag, "_err"}, 32'(beats[beats.size()-1].err), 32'(exp_err));
    end
  endtask

  task automatic check_cnt(input string tag, input int good, input int bad);
    check({tag, "_cnt_good"}, 32'(cnt_good), 32'(good));
    check({tag, "_cnt_bad"}, 32'(cnt_bad), 32'(bad));
  endtask

  initial begin
    int neof;
    rst = 1'b0;
    repeat (3) tick();
    check("reset_out_val", 32'(out_val), 32'd0);
    check("reset_out_sof", 32'(out_sof), 32'd0);
    check("reset_out_eof", 32'(out_eof), 32'd0);
    check_cnt("reset", 0, 0);
    rst = 1'b1;
    tick();

    build(60);
    send(7, -1, -1, -1, 1'b1);
    check_frame("good60", 60, 1'b1, 1'b0);
    check_cnt("good60", 1, 0);

    send(7, 10, -1, -1, 1'b1);
    check_frame("badfcs", 60, 1'b0, 1'b1);
    check_cnt("badfcs", 1, 1);

    send(3, -1, -1, -1, 1'b1);
    check("shortpre_beats", 32'(beats.size()), 32'd0);
    check_cnt("shortpre", 1, 2);

    send(5, -1, -1, -1, 1'b1);
    check_frame("pre5", 60, 1'b1, 1'b0);
    check_cnt("pre5", 2, 2);

    build(40);
    send(7, -1, -1, -1, 1'b1);
    check_frame("runt40", 40, 1'b1, 1'b1);
    check_cnt("runt40", 2, 3);

    build(60);
    send(7, -1, 20, -1, 1'b1);
    check_frame("inerr", 60, 1'b1, 1'b1);
    check_cnt("inerr", 2, 4);

    build(59);
    send(7, -1, -1, -1, 1'b1);
    check_frame("runt59", 59, 1'b1, 1'b1);
    check_cnt("runt59", 2, 5);

    build(1);
    send(7, -1, -1, -1, 1'b1);
    check_frame("len5", 1, 1'b1, 1'b1);
    check_cnt("len5", 2, 6);

    build(3);
    send(7, -1, -1, -1, 1'b0);
    check("len3_beats", 32'(beats.size()), 32'd0);
    check_cnt("len3", 2, 7);

    build(1514);
    send(7, -1, -1, -1, 1'b1);
    check_frame("max1514", 1514, 1'b1, 1'b0);
    check_cnt("max1514", 3, 7);

    build(1515);
    send(7, -1, -1, -1, 1'b1);
    check_frame("giant1515", 1515, 1'b1, 1'b1);
    check_cnt("giant1515", 3, 8);

    build(60);
    send(7, -1, -1, 30, 1'b1);
    neof = 0;
    foreach (beats[i]) if (beats[i].eof) neof++;
    check("abort_eof_cnt", 32'(neof), 32'd0);
    check_cnt("abort", 0, 1);

    send(7, -1, -1, -1, 1'b1);
    check_frame("after_rst", 60, 1'b1, 1'b0);
    check_cnt("after_rst", 1, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
